// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic unit: op codes, FSM states, default word length.
package serial_arith_pkg;

  localparam int unsigned DefaultWidth = 26;

  typedef enum logic [2:0] {
    OpAdd   = 3'd0,
    OpSub   = 3'd1,
    OpRsub  = 3'd2,
    OpAnd   = 3'd3,
    OpXor   = 3'd4,
    OpPassb = 3'd5,
    OpShr   = 3'd6,
    OpShl   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Subtractions start with carry-in 1 so that x + ~y + 1 forms the difference.
  function automatic logic op_is_sub(op_e op);
    return (op == OpSub) || (op == OpRsub);
  endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit ALU slice: operand swap/invert, full adder, logic mux and the carry latch.
// Optional overflow detect output is present when SERIAL_ARITH_OVF_EN is defined.
module serial_alu_bit
  import serial_arith_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  input  op_e  op_i,
  input  logic a_bit_i,
  input  logic a_next_i,
  input  logic b_bit_i,
  output logic r_bit_o,
  output logic carry_o
`ifdef SERIAL_ARITH_OVF_EN
  ,
  output logic ovf_o
`endif
);

  logic carry_q, carry_d;
  logic x, y, sum, cout;

  always_comb begin
    x = a_bit_i;
    y = b_bit_i;
    if (op_i == OpSub) begin
      y = ~b_bit_i;
    end else if (op_i == OpRsub) begin
      x = b_bit_i;
      y = ~a_bit_i;
    end
    sum  = x ^ y ^ carry_q;
    cout = (x & y) | (carry_q & (x ^ y));
  end

  always_comb begin
    r_bit_o = sum;
    carry_d = cout;
    unique case (op_i)
      OpAdd, OpSub, OpRsub: begin
        r_bit_o = sum;
        carry_d = cout;
      end
      OpAnd: begin
        r_bit_o = a_bit_i & b_bit_i;
        carry_d = 1'b0;
      end
      OpXor: begin
        r_bit_o = a_bit_i ^ b_bit_i;
        carry_d = 1'b0;
      end
      OpPassb: begin
        r_bit_o = b_bit_i;
        carry_d = 1'b0;
      end
      OpShr: begin
        r_bit_o = a_next_i;
        carry_d = 1'b0;
      end
      // The latch acts as a one-bit delay line: emit A[k-1], capture A[k].
      OpShl: begin
        r_bit_o = carry_q;
        carry_d = a_bit_i;
      end
    endcase
  end

`ifdef SERIAL_ARITH_OVF_EN
  // Meaningful only on the sign bit; the top samples it on the last RUN cycle.
  assign ovf_o = (op_i == OpAdd || op_i == OpSub || op_i == OpRsub) && (x == y) && (sum != x);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      carry_q <= 1'b0;
    end else if (load_i) begin
      carry_q <= op_is_sub(op_i);
    end else if (en_i) begin
      carry_q <= carry_d;
    end
  end

  assign carry_o = carry_q;

endmodule

// File: rtl/serial_arith_unit.sv
// Bit-serial arithmetic/logic unit: parallel load, LSB-first processing, parallel result.
// Defining SERIAL_ARITH_OVF_EN adds the two's-complement overflow flag output.
module serial_arith_unit
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             r_bit_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o
`ifdef SERIAL_ARITH_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  op_e              op_q, op_d;
  logic             zero_q, zero_d;

  logic             load, run, last, alu_r;
  op_e              alu_op;
  logic [WIDTH-1:0] res_shift;

  assign load      = (state_q == StIdle) && start_i;
  assign run       = (state_q == StRun);
  assign last      = run && (cnt_q == CNTW'(WIDTH - 1));
  // The slice needs the incoming op on the load edge to pick its carry-in.
  assign alu_op    = load ? op_e'(op_i) : op_q;
  assign res_shift = {alu_r, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          cnt_d   = '0;
          a_d     = a_i;
          b_d     = b_i;
          op_d    = op_e'(op_i);
        end
      end
      StRun: begin
        // A shifts arithmetically so a_q[1] yields the sign bit on the final SHR step.
        a_d   = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = res_shift;
        cnt_d = cnt_q + CNTW'(1);
        if (last) begin
          state_d = StDone;
          cnt_d   = '0;
          zero_d  = (res_shift == '0);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OpAdd;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

`ifdef SERIAL_ARITH_OVF_EN
  logic alu_ovf, ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= alu_ovf;
    end
  end

  assign ovf_o = ovf_q;
`endif

  serial_alu_bit u_alu_bit (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (load),
    .en_i     (run),
    .op_i     (alu_op),
    .a_bit_i  (a_q[0]),
    .a_next_i (a_q[1]),
    .b_bit_i  (b_q[0]),
    .r_bit_o  (alu_r),
    .carry_o  (carry_o)
`ifdef SERIAL_ARITH_OVF_EN
    ,
    .ovf_o    (alu_ovf)
`endif
  );

  assign busy_o   = run;
  assign done_o   = (state_q == StDone);
  assign r_bit_o  = run & alu_r;
  assign result_o = res_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_serial_arith_unit.sv
// Self-checking bench for serial_arith_unit (WIDTH=26), directed and randomized operations.
// Checks the ovf flag too when SERIAL_ARITH_OVF_EN is defined.
module tb_serial_arith_unit;

  localparam int unsigned W   = 26;
  localparam int          Lat = W + 1;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, r_bit, carry, zero;
  logic [W-1:0] result;
`ifdef SERIAL_ARITH_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_arith_unit #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .r_bit_o  (r_bit),
    .result_o (result),
    .carry_o  (carry),
    .zero_o   (zero)
`ifdef SERIAL_ARITH_OVF_EN
    ,
    .ovf_o    (ovf)
`endif
  );

  int checks = 0;
  int failures = 0;

  int           obs_lat, obs_nbits;
  logic [W-1:0] obs_res, obs_stream;
  logic         obs_c, obs_z, obs_v, obs_busy;

  // Reference: whole-word arithmetic straight from the op definitions.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] r, output logic c, output logic v);
    logic sa, sb;
    sa = av[W-1];
    sb = bv[W-1];
    c  = 1'b0;
    case (o)
      3'd0: {c, r} = {1'b0, av} + {1'b0, bv};
      3'd1: begin r = av - bv; c = (av >= bv); end
      3'd2: begin r = bv - av; c = (bv >= av); end
      3'd3: r = av & bv;
      3'd4: r = av ^ bv;
      3'd5: r = bv;
      3'd6: r = $signed(av) >>> 1;
      default: begin r = av << 1; c = av[W-1]; end
    endcase
    case (o)
      3'd0:    v = (sa == sb) && (r[W-1] != sa);
      3'd1:    v = (sa != sb) && (r[W-1] != sa);
      3'd2:    v = (sa != sb) && (r[W-1] != sb);
      default: v = 1'b0;
    endcase
  endfunction

  // Call at a falling edge. Drives one start, collects the serial stream, returns at done.
  // glitch_at pulses start again with junk operands; rst_at asserts reset mid-run and returns.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int glitch_at, input int rst_at);
    start = 1'b1;
    op = o;
    a = av;
    b = bv;
    obs_lat = 0;
    obs_nbits = 0;
    obs_stream = '0;
    obs_res = 'x;
    obs_c = 1'bx;
    obs_z = 1'bx;
    obs_v = 1'bx;
    obs_busy = 1'bx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      obs_lat++;
      if (busy) begin
        if (obs_nbits < int'(W)) obs_stream[obs_nbits] = r_bit;
        obs_nbits++;
      end
      if (done) begin
        obs_res = result;
        obs_c = carry;
        obs_z = zero;
        obs_busy = busy;
`ifdef SERIAL_ARITH_OVF_EN
        obs_v = ovf;
`else
        obs_v = 1'b0;
`endif
        start = 1'b0;
        return;
      end
      if (obs_lat == 1 || obs_lat == glitch_at + 1) begin
        start = 1'b0;
        op = 3'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      if (obs_lat == glitch_at) begin
        start = 1'b1;
        op = 3'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      if (obs_lat == rst_at) begin
        rst_ni = 1'b0;
        return;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, r_bit, carry, zero} !== 5'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b r_bit=%b carry=%b zero=%b result=%h, want all 0",
               busy, done, r_bit, carry, zero, result);
    end
`ifdef SERIAL_ARITH_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    rst_ni = 1'b1;
    do_op(3'd0, W'(5), W'(3), -1, -1);
    checks++;
    if (obs_lat != Lat || obs_res !== W'(8) || obs_c !== 1'b0 || obs_z !== 1'b0) begin
      failures++;
      $display("FAIL first_start_after_reset: got lat=%0d res=%h c=%b z=%b, want lat=%0d res=8 c=0 z=0",
               obs_lat, obs_res, obs_c, obs_z, Lat);
    end
  endtask

  task automatic test_directed;
    logic [2:0]   t_op[7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd6, 3'd7, 3'd4};
    logic [W-1:0] t_a[7]  = '{W'(5), W'(3), W'(3), W'('h1FFFFFF), W'('h2000004), W'('h2000003),
                              W'('h155)};
    logic [W-1:0] t_b[7]  = '{W'(3), W'(5), W'(5), W'(1), W'(0), W'(0), W'('h155)};
    logic [W-1:0] t_r[7]  = '{W'(8), W'('h3FFFFFE), W'(2), W'('h2000000), W'('h3000002),
                              W'('h0000006), W'(0)};
    logic         t_c[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         t_z[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         t_v[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      do_op(t_op[i], t_a[i], t_b[i], -1, -1);
      checks++;
      if (obs_lat != Lat || obs_busy !== 1'b0) begin
        failures++;
        $display("FAIL directed%0d_latency: got lat=%0d busy=%b, want lat=%0d busy=0",
                 i, obs_lat, obs_busy, Lat);
      end
      checks++;
      if (obs_res !== t_r[i] || obs_c !== t_c[i] || obs_z !== t_z[i]) begin
        failures++;
        $display("FAIL directed%0d_result: got res=%h c=%b z=%b, want res=%h c=%b z=%b",
                 i, obs_res, obs_c, obs_z, t_r[i], t_c[i], t_z[i]);
      end
      checks++;
      if (obs_stream !== t_r[i] || obs_nbits != int'(W)) begin
        failures++;
        $display("FAIL directed%0d_stream: got bits=%h n=%0d, want bits=%h n=%0d",
                 i, obs_stream, obs_nbits, t_r[i], W);
      end
`ifdef SERIAL_ARITH_OVF_EN
      checks++;
      if (obs_v !== t_v[i]) begin
        failures++;
        $display("FAIL directed%0d_ovf: got %b want %b", i, obs_v, t_v[i]);
      end
`endif
    end
  endtask

  task automatic test_random;
    logic [2:0]   o;
    logic [W-1:0] av, bv, er;
    logic         ec, ev;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      av = W'($urandom);
      bv = W'($urandom);
      if (i % 8 == 0) bv = av;
      model(o, av, bv, er, ec, ev);
      @(negedge clk);
      do_op(o, av, bv, -1, -1);
      checks++;
      if (obs_lat != Lat || obs_res !== er || obs_c !== ec || obs_z !== (er == '0)) begin
        failures++;
        $display("FAIL random%0d op=%0d a=%h b=%h: got lat=%0d res=%h c=%b z=%b, want lat=%0d res=%h c=%b z=%b",
                 i, o, av, bv, obs_lat, obs_res, obs_c, obs_z, Lat, er, ec, (er == '0));
      end
      checks++;
      if (obs_stream !== er || obs_nbits != int'(W)) begin
        failures++;
        $display("FAIL random%0d_stream: got bits=%h n=%0d, want bits=%h n=%0d",
                 i, obs_stream, obs_nbits, er, W);
      end
`ifdef SERIAL_ARITH_OVF_EN
      checks++;
      if (obs_v !== ev) begin
        failures++;
        $display("FAIL random%0d_ovf op=%0d: got %b want %b", i, o, obs_v, ev);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av, bv, er, er2;
    logic         ec, ev, ec2;
    av = W'($urandom);
    bv = W'($urandom);
    model(3'd1, av, bv, er, ec, ev);
    @(negedge clk);
    do_op(3'd1, av, bv, 11, -1);
    checks++;
    if (obs_lat != Lat || obs_res !== er || obs_c !== ec) begin
      failures++;
      $display("FAIL start_in_run_ignored: got lat=%0d res=%h c=%b, want lat=%0d res=%h c=%b",
               obs_lat, obs_res, obs_c, Lat, er, ec);
    end
    @(negedge clk);
    checks++;
    if (result !== er || carry !== ec || zero !== (er == '0) || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_after_done: got res=%h c=%b z=%b busy=%b, want res=%h c=%b z=%b busy=0",
               result, carry, zero, busy, er, ec, (er == '0));
    end
    av = W'($urandom);
    bv = W'($urandom);
    model(3'd7, av, bv, er2, ec2, ev);
    do_op(3'd7, av, bv, -1, -1);
    checks++;
    if (obs_lat != Lat || obs_res !== er2 || obs_c !== ec2) begin
      failures++;
      $display("FAIL back_to_back: got lat=%0d res=%h c=%b, want lat=%0d res=%h c=%b",
               obs_lat, obs_res, obs_c, Lat, er2, ec2);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] av, bv, er;
    logic         ec, ev;
    int           done_seen;
    @(negedge clk);
    do_op(3'd0, W'($urandom), W'($urandom), -1, 13);
    #1;
    checks++;
    if ({busy, done, r_bit, carry, zero} !== 5'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset_mid_run: got busy=%b done=%b r_bit=%b carry=%b zero=%b result=%h, want all 0",
               busy, done, r_bit, carry, zero, result);
    end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_ni = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL no_done_after_abort: got %0d done/busy cycles, want 0", done_seen);
    end
    av = W'($urandom);
    bv = W'($urandom);
    model(3'd0, av, bv, er, ec, ev);
    do_op(3'd0, av, bv, -1, -1);
    checks++;
    if (obs_lat != Lat || obs_res !== er || obs_c !== ec) begin
      failures++;
      $display("FAIL add_after_abort: got lat=%0d res=%h c=%b, want lat=%0d res=%h c=%b",
               obs_lat, obs_res, obs_c, Lat, er, ec);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/serial_arith_unit.md
SERIAL_ARITH_UNIT -- requirements
Module: serial_arith_unit

Interface
REQ-001 Parameter WIDTH, default 26: operand/result word length in bits, legal range 4..64.
REQ-002 Parameter CNTW, default $clog2(WIDTH): width of the bit counter.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 op  in  3  operation code, latched with start.
REQ-007 a_in  in  WIDTH  operand A, parallel, latched with start.
REQ-008 b_in  in  WIDTH  operand B, parallel, latched with start.
REQ-009 busy  out  1  high while in RUN.
REQ-010 done  out  1  one-cycle pulse; result and flags valid.
REQ-011 r_bit  out  1  serial result bit for the current RUN cycle, LSB first.
REQ-012 result  out  WIDTH  parallel result register.
REQ-013 carry  out  1  final carry latch value.
REQ-014 zero  out  1  result == 0, valid with done.
REQ-015 ovf  out  1  two's-complement overflow; present only under REQ-030.

Function
REQ-016 op codes: 0 ADD A+B; 1 SUB A-B; 2 RSUB B-A; 3 AND; 4 XOR; 5 PASSB; 6 SHR (A arithmetic right by 1); 7 SHL (A left by 1, zero fill).
REQ-017 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after bit WIDTH-1; DONE->IDLE unconditionally.
REQ-018 Start edge loads the A/B shift registers, op and carry-init; carry-init = 1 for SUB/RSUB, 0 for all other ops.
REQ-019 RUN cycle k (k = 0..WIDTH-1) processes bit k: one full-adder step with carry latch update; the subtrahend is inverted for SUB/RSUB.
REQ-020 SHL uses the carry latch as a one-bit delay: bit k = A[k-1], bit 0 = 0.
REQ-021 SHR: bit k = A[k+1]; bit WIDTH-1 = A[WIDTH-1].
REQ-022 Result shifts in MSB-side each RUN cycle; after WIDTH cycles it is fully aligned.
REQ-023 Latency: done asserts in the cycle WIDTH+1 clocks after the start edge; the block accepts a new start in the cycle after done.
REQ-024 start in RUN or DONE is ignored with no side effects; op/a_in/b_in changes outside the start edge are ignored.
REQ-025 result, carry, zero and ovf hold from done until the next start edge.
REQ-026 The carry output for logical and shift ops is the final latch value (0 for AND/XOR/PASSB; A[WIDTH-1] for SHL).

Reset
REQ-027 rst_n low forces IDLE and clears busy, done, r_bit, result, carry, zero, ovf, shift registers and counter.
REQ-028 Reset asserted mid-RUN aborts the operation; no done pulse follows.
REQ-029 The first start is accepted in the first clock after rst_n deasserts.

Configuration
REQ-030 Macro SERIAL_ARITH_OVF_EN defined: the ovf port exists and is set at done for ADD/SUB/RSUB when the effective operand signs match and the result sign differs, and is 0 for other ops. Undefined: the ovf port and its logic are absent.

Structure
REQ-031 Package serial_arith_pkg holds the op enum, the state enum and the default-WIDTH constant.
REQ-032 Sub-module serial_alu_bit holds the one-bit slice: full adder, invert control, logic mux and carry flip-flop; it is instantiated once.

Verification (WIDTH=26)
REQ-033 ADD a=5 b=3 -> done 27 clocks after start; result=8, carry=0, zero=0.
REQ-034 SUB a=3 b=5 -> result=0x3FFFFFE, carry=0; RSUB with the same operands -> result=2, carry=1.
REQ-035 ADD a=0x1FFFFFF b=1 -> result=0x2000000, ovf=1 (macro on); the ovf port is absent with the macro off.
REQ-036 SHR a=0x2000004 -> 0x3000002; SHL a=0x2000003 -> 0x0000006, carry=1.
REQ-037 start pulsed at RUN cycle 10 with different operands -> ignored; original result delivered; back-to-back start after done accepted.
REQ-038 rst_n low at RUN cycle 12 -> all outputs 0 and state IDLE; no done pulse; the next ADD completes normally.
